jzjcoref_port_uart: RTL and testbench
=====================================

Name: jzjcoref_port_uart

Overview:
- UART peripheral attached to one memory-mapped port pair of the core.
- Consumes the port's output register, portXOutput, as a command word and drives the same port's input, portXInput, as a status word.
- Software transmits and receives bytes through a toggle handshake. No extra strobes are needed from the core; the block runs in the core's clock domain.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- SYNC_STAGES, 2, flip-flop stages on the rxd input synchronizer (>= 2).

Ports:
- clock  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- portOutputWord  input  32  command word from the core's port output register
- portInputWord  output  32  status word to the core's port input
- rxd  input  1  serial receive line, asynchronous, idle high
- txd  output  1  serial transmit line, idle high

Behaviour:
- Command word fields: [7:0] txData; [8] txReqToggle; [9] rxAckToggle; [31:10] ignored.
- Status word fields: [7:0] rxData; [8] txDoneToggle; [9] rxValidToggle; [10] txBusy; [11] rxOverrun; [12] rxFramingError; [31:13] = 0. All status bits are registered.
- Frame format: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- Reset (asynchronous):
  - txd=1, portInputWord=0.
  - TX and RX FSMs go to IDLE; bit counters and timers are cleared.
  - Synchronizer flops are set to 1.
  - Reset mid-frame aborts immediately; txd returns to 1 during reset.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: on a clock edge where txReqToggle != txDoneToggle, latch txData and the current txReqToggle, set txBusy=1, go to START. txd drives 0 from the next cycle.
  - START, DATA and STOP each last exactly CLKS_PER_BIT cycles per bit; DATA shifts out 8 bits.
  - End of STOP: txDoneToggle := latched toggle, txBusy=0, go to IDLE. A full frame is 10*CLKS_PER_BIT cycles.
  - Command changes during busy are ignored. If the toggle still mismatches when the FSM returns to IDLE, a new frame starts with the then-current txData; the STOP-to-START gap is exactly 1 cycle.
- RX FSM (IDLE, START, DATA, STOP) runs on the synchronized rxd:
  - IDLE: on a falling edge, go to START.
  - START: sample at CLKS_PER_BIT/2 (integer divide). If the sample is 1 (glitch), return to IDLE with no status change.
  - DATA: each subsequent sample is taken CLKS_PER_BIT cycles after the previous one; 8 samples, LSB first.
  - STOP: sample the stop bit.
- Byte completion (on the stop-bit sample):
  - If no byte is pending (rxValidToggle == rxAckToggle): rxData := byte, rxFramingError := !stopBit, invert rxValidToggle.
  - If a byte is pending: discard the new byte and set rxOverrun=1.
  - In both cases return to IDLE. A stop bit of 0 still delivers the byte, with the error flag set.
- Acknowledge:
  - rxAckToggle is compared combinationally every cycle.
  - rxOverrun clears on the first cycle in which rxAckToggle changes value; the block keeps a registered copy of rxAckToggle to detect the change.
  - If an ack and a completion occur in the same cycle, the ack is evaluated first, so the new byte is accepted and the overrun flag is not set.

Optional Feature:
- Macro: JZJCOREF_UART_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit between the data and stop bits (11-bit frame).
  - RX checks that bit; status[13] = rxParityError, updated together with rxData.
- Undefined: 10-bit frame and status[13]=0; no parity logic is synthesized.

Decomposition:
- Shared package JZJCoreFTypes gains:
  - UartTxState_t and UartRxState_t enums;
  - localparams for the command/status field bit positions (UART_TX_DATA_LSB, UART_TX_REQ_BIT, UART_RX_ACK_BIT, UART_STAT_*).
- One natural sub-module, jzjcoref_uart_rx: synchronizer, RX FSM, and sampling timer. It outputs a byte, a done strobe, and a frame-error flag.
- TX FSM and the status/handshake registers stay in the top.

Test Plan (CLKS_PER_BIT=4):
- Reset: assert reset mid-TX frame -> txd=1 and portInputWord=0 while reset is high; after release, txd stays 1 with no command change.
- Send 0xA5 by writing command 0x1A5:
  - txd goes low one cycle later.
  - Bits 1,0,1,0,0,1,0,1 follow, each 4 cycles.
  - Stop bit is high.
  - status[8]=1 and status[10]=0 at cycle 40 from start.
- Receive 0x3C on rxd:
  - status[7:0]=0x3C and status[9] toggles to 1 within SYNC_STAGES+2 cycles of the stop-bit sample.
  - Writing command bit 9=1 leaves status[11]=0.
- Overrun and simultaneous ack:
  - Receive 0x11, then 0x22 without an ack -> rxData stays 0x11, status[11]=1.
  - Ack -> status[11]=0.
  - Ack coinciding with the 0x33 completion -> rxData=0x33, no overrun.
- Error cases:
  - 1-cycle low glitch on rxd -> no status change.
  - Frame 0x55 with stop bit=0 -> rxData=0x55, status[12]=1.
- Back-to-back TX: toggle bit 8 twice during busy -> exactly 2 frames total, with a 1-cycle gap between them.

Source files
------------

// File: rtl/jzjcoref_port_uart_pkg.sv
// Shared types and field positions for the port-mapped UART.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional parity build: JZJCOREF_UART_PARITY_EN.
package jzjcoref_port_uart_pkg;

`ifdef JZJCOREF_UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} UartTxState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} UartRxState_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} UartTxState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} UartRxState_t;
`endif

  // Command word (core -> UART)
  localparam int UART_TX_DATA_LSB = 0;
  localparam int UART_TX_REQ_BIT  = 8;
  localparam int UART_RX_ACK_BIT  = 9;

  // Status word (UART -> core)
  localparam int UART_STAT_RX_DATA_LSB  = 0;
  localparam int UART_STAT_TX_DONE_BIT  = 8;
  localparam int UART_STAT_RX_VALID_BIT = 9;
  localparam int UART_STAT_TX_BUSY_BIT  = 10;
  localparam int UART_STAT_RX_OVR_BIT   = 11;
  localparam int UART_STAT_RX_FERR_BIT  = 12;
  localparam int UART_STAT_RX_PERR_BIT  = 13;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic uart_even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/jzjcoref_port_uart_if.sv
// Port-register pair between the core and the UART (command out, status in).
// Latency: none, plain wires.
// Backpressure: none; flow control is the toggle handshake carried in the words.
interface jzjcoref_port_uart_if;
  logic [31:0] portOutputWord;
  logic [31:0] portInputWord;

  modport master (output portOutputWord, input portInputWord);
  modport slave  (input portOutputWord, output portInputWord);
endinterface

// File: rtl/jzjcoref_uart_rx.sv
// UART receiver: rxd synchronizer, mid-bit sampling timer and RX FSM.
// Latency: done strobe one cycle after the stop-bit sample.
// Backpressure: none; the byte is presented for one cycle. Parity: JZJCOREF_UART_PARITY_EN.
module jzjcoref_uart_rx
  import jzjcoref_port_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte_o,
  output logic       rx_done_o,
`ifdef JZJCOREF_UART_PARITY_EN
  output logic       rx_parity_err_o,
`endif
  output logic       rx_frame_err_o
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rx_s;

  UartRxState_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
`ifdef JZJCOREF_UART_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain and previous-value flop for falling-edge detection; idle-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      prev_q <= rx_s;
    end
  end

  // RX state, timer and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      byte_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef JZJCOREF_UART_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      byte_q   <= byte_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
`ifdef JZJCOREF_UART_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  // Next-state: start bit checked at half a bit, later samples one bit period apart.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    byte_d   = byte_q;
    done_d   = 1'b0;
    ferr_d   = ferr_q;
`ifdef JZJCOREF_UART_PARITY_EN
    par_d    = par_q;
    perr_d   = perr_q;
`endif
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          timer_d = '0;
        end
      end
      RX_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = rx_s ? RX_IDLE : RX_DATA;  // high at mid-start means a glitch
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RX_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) begin
`ifdef JZJCOREF_UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef JZJCOREF_UART_PARITY_EN
      RX_PARITY: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          par_d   = rx_s;
          state_d = RX_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          done_d  = 1'b1;
          byte_d  = shreg_q;
          ferr_d  = !rx_s;  // byte still delivered on a bad stop bit
`ifdef JZJCOREF_UART_PARITY_EN
          perr_d  = par_q ^ uart_even_parity(shreg_q);
`endif
          state_d = RX_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte_o      = byte_q;
  assign rx_done_o      = done_q;
  assign rx_frame_err_o = ferr_q;
`ifdef JZJCOREF_UART_PARITY_EN
  assign rx_parity_err_o = perr_q;
`endif

endmodule

// File: rtl/jzjcoref_port_uart.sv
// Port-mapped UART: TX FSM plus toggle-handshake status registers; RX in jzjcoref_uart_rx.
// Latency: txd start bit one cycle after a request toggle; status one cycle after RX done.
// Backpressure: toggle handshake; new RX bytes while one is pending set overrun. Parity: JZJCOREF_UART_PARITY_EN.
module jzjcoref_port_uart
  import jzjcoref_port_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  jzjcoref_port_uart_if.slave   port,
  input  logic                  rxd,
  output logic                  txd
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  logic [7:0] cmd_tx_data;
  logic       cmd_tx_req;
  logic       cmd_rx_ack;
  logic       unused_cmd;

  assign cmd_tx_data = port.portOutputWord[UART_TX_DATA_LSB +: 8];
  assign cmd_tx_req  = port.portOutputWord[UART_TX_REQ_BIT];
  assign cmd_rx_ack  = port.portOutputWord[UART_RX_ACK_BIT];
  assign unused_cmd  = ^port.portOutputWord[31:10];

  // ---------------- TX ----------------
  UartTxState_t tx_state_q, tx_state_d;
  logic [TW-1:0] tx_timer_q, tx_timer_d;
  logic [2:0]    tx_bitcnt_q, tx_bitcnt_d;
  logic [7:0]    tx_shreg_q, tx_shreg_d;
  logic          tx_tog_q, tx_tog_d;
  logic          txd_q, txd_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;
`ifdef JZJCOREF_UART_PARITY_EN
  logic          tx_par_q, tx_par_d;
`endif

  // TX state register; txd is registered so it is glitch-free and idles high in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      tx_timer_q  <= '0;
      tx_bitcnt_q <= '0;
      tx_shreg_q  <= '0;
      tx_tog_q    <= 1'b0;
      txd_q       <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef JZJCOREF_UART_PARITY_EN
      tx_par_q    <= 1'b0;
`endif
    end else begin
      tx_state_q  <= tx_state_d;
      tx_timer_q  <= tx_timer_d;
      tx_bitcnt_q <= tx_bitcnt_d;
      tx_shreg_q  <= tx_shreg_d;
      tx_tog_q    <= tx_tog_d;
      txd_q       <= txd_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
`ifdef JZJCOREF_UART_PARITY_EN
      tx_par_q    <= tx_par_d;
`endif
    end
  end

  // TX next-state: txd_d is the level for the coming bit, so each bit lasts exactly CLKS_PER_BIT.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_timer_d  = tx_timer_q;
    tx_bitcnt_d = tx_bitcnt_q;
    tx_shreg_d  = tx_shreg_q;
    tx_tog_d    = tx_tog_q;
    txd_d       = txd_q;
    tx_busy_d   = tx_busy_q;
    tx_done_d   = tx_done_q;
`ifdef JZJCOREF_UART_PARITY_EN
    tx_par_d    = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        if (cmd_tx_req != tx_done_q) begin
          tx_shreg_d = cmd_tx_data;
          tx_tog_d   = cmd_tx_req;
          tx_busy_d  = 1'b1;
          tx_timer_d = '0;
          txd_d      = 1'b0;
`ifdef JZJCOREF_UART_PARITY_EN
          tx_par_d   = uart_even_parity(cmd_tx_data);
`endif
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d  = '0;
          tx_bitcnt_d = '0;
          txd_d       = tx_shreg_q[0];
          tx_shreg_d  = tx_shreg_q >> 1;
          tx_state_d  = TX_DATA;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      TX_DATA: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = '0;
          if (tx_bitcnt_q == 3'd7) begin
`ifdef JZJCOREF_UART_PARITY_EN
            txd_d      = tx_par_q;
            tx_state_d = TX_PARITY;
`else
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_bitcnt_d = tx_bitcnt_q + 3'd1;
            txd_d       = tx_shreg_q[0];
            tx_shreg_d  = tx_shreg_q >> 1;
          end
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
`ifdef JZJCOREF_UART_PARITY_EN
      TX_PARITY: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = '0;
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
`endif
      TX_STOP: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = '0;
          tx_done_d  = tx_tog_q;
          tx_busy_d  = 1'b0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign txd = txd_q;

  // ---------------- RX ----------------
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_ferr;
`ifdef JZJCOREF_UART_PARITY_EN
  logic       rx_perr;
`endif

  jzjcoref_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clock          (clock),
    .reset          (reset),
    .rxd            (rxd),
    .rx_byte_o      (rx_byte),
    .rx_done_o      (rx_done),
`ifdef JZJCOREF_UART_PARITY_EN
    .rx_parity_err_o(rx_perr),
`endif
    .rx_frame_err_o (rx_ferr)
  );

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       rx_ferr_q, rx_ferr_d;
  logic       ack_prev_q;
`ifdef JZJCOREF_UART_PARITY_EN
  logic       rx_perr_q, rx_perr_d;
`endif

  // RX status registers and the registered ack copy used for change detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      ack_prev_q <= 1'b0;
`ifdef JZJCOREF_UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      ack_prev_q <= cmd_rx_ack;
`ifdef JZJCOREF_UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  // Pending is judged against the live ack, so an ack landing with a completion frees the slot first.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
`ifdef JZJCOREF_UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    if (cmd_rx_ack != ack_prev_q) begin
      rx_ovr_d = 1'b0;
    end
    if (rx_done) begin
      if (rx_valid_q == cmd_rx_ack) begin
        rx_data_d  = rx_byte;
        rx_ferr_d  = rx_ferr;
        rx_valid_d = !rx_valid_q;
`ifdef JZJCOREF_UART_PARITY_EN
        rx_perr_d  = rx_perr;
`endif
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  // Status word assembled from registers only.
  always_comb begin
    port.portInputWord = '0;
    port.portInputWord[UART_STAT_RX_DATA_LSB +: 8] = rx_data_q;
    port.portInputWord[UART_STAT_TX_DONE_BIT]      = tx_done_q;
    port.portInputWord[UART_STAT_RX_VALID_BIT]     = rx_valid_q;
    port.portInputWord[UART_STAT_TX_BUSY_BIT]      = tx_busy_q;
    port.portInputWord[UART_STAT_RX_OVR_BIT]       = rx_ovr_q;
    port.portInputWord[UART_STAT_RX_FERR_BIT]      = rx_ferr_q;
`ifdef JZJCOREF_UART_PARITY_EN
    port.portInputWord[UART_STAT_RX_PERR_BIT]      = rx_perr_q;
`endif
  end

endmodule

// File: tb/tb_jzjcoref_port_uart.sv
// Directed bench for jzjcoref_port_uart at CLKS_PER_BIT=4.
// Inputs driven and outputs sampled on the falling clock edge.
// Frame length follows JZJCOREF_UART_PARITY_EN.
module tb_jzjcoref_port_uart;
  localparam int CPB  = 4;
  localparam int SYNC = 2;
`ifdef JZJCOREF_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * CPB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rxd   = 1'b1;
  logic txd;

  int checks   = 0;
  int failures = 0;

  jzjcoref_port_uart_if pif ();

  jzjcoref_port_uart #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clock(clock),
    .reset(reset),
    .port (pif),
    .rxd  (rxd),
    .txd  (txd)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stopb);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef JZJCOREF_UART_PARITY_EN
    f[9] = ^b;
`endif
    f[FB-1] = stopb;
    return f;
  endfunction

  // Drive one frame on rxd; returns on the falling edge just before the stop-bit sample.
  task automatic send_byte(input logic [7:0] b, input logic stopb);
    logic [10:0] f;
    f = frame_bits(b, stopb);
    for (int i = 0; i < FB; i++) begin
      rxd = f[i];
      cyc(CPB);
    end
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    cyc(1);
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++;
    if (pif.portInputWord !== 32'h0) begin failures++; $display("FAIL reset_status: got %h want 0", pif.portInputWord); end
    reset = 1'b0;
    cyc(3);
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL post_reset_idle_txd: got %b want 1", txd); end
  endtask

  task automatic test_tx;
    logic       tl [0:FL+2];
    logic [1:0] sl [0:FL+2];
    logic [10:0] f;
    int bad;
    f = frame_bits(8'hA5, 1'b1);
    pif.portOutputWord = 32'h0000_01A5;
    for (int n = 0; n <= FL + 2; n++) begin
      cyc(1);
      tl[n] = txd;
      sl[n] = {pif.portInputWord[10], pif.portInputWord[8]};
      if (n == FL) begin
        checks++;
        if (pif.portInputWord !== 32'h0000_0100) begin failures++; $display("FAIL tx_done_status: got %h want 00000100", pif.portInputWord); end
      end
    end
    checks++;
    if (tl[0] !== 1'b0) begin failures++; $display("FAIL tx_start_latency: got %b want 0", tl[0]); end
    checks++;
    if (sl[0] !== 2'b10) begin failures++; $display("FAIL tx_busy_set: got %b want 10", sl[0]); end
    for (int k = 0; k < FB; k++) begin
      bad = 0;
      for (int j = 0; j < CPB; j++) if (tl[k*CPB + j] !== f[k]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL tx_bit%0d: %0d cycles wrong, want level %b", k, bad, f[k]); end
    end
    checks++;
    if (sl[FL-1] !== 2'b10) begin failures++; $display("FAIL tx_busy_last_cycle: got %b want 10", sl[FL-1]); end
    checks++;
    if (sl[FL] !== 2'b01) begin failures++; $display("FAIL tx_done_at_end: got %b want 01", sl[FL]); end
    checks++;
    if (tl[FL+2] !== 1'b1 || sl[FL+2] !== 2'b01) begin failures++; $display("FAIL tx_no_extra_frame: txd %b st %b want 1 01", tl[FL+2], sl[FL+2]); end
  endtask

  task automatic test_reset_midframe;
    int bad;
    pif.portOutputWord = 32'h0000_0000;  // request toggle 0 vs done 1 starts a frame of 0x00
    cyc(10);
    checks++;
    if (txd !== 1'b0) begin failures++; $display("FAIL midframe_low: got %b want 0", txd); end
    reset = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL reset_abort_txd: got %b want 1", txd); end
    checks++;
    if (pif.portInputWord !== 32'h0) begin failures++; $display("FAIL reset_abort_status: got %h want 0", pif.portInputWord); end
    cyc(3);
    checks++;
    if (txd !== 1'b1 || pif.portInputWord !== 32'h0) begin failures++; $display("FAIL reset_hold: txd %b status %h want 1 0", txd, pif.portInputWord); end
    reset = 1'b0;
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      cyc(1);
      if (txd !== 1'b1 || pif.portInputWord !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL after_reset_quiet: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_rx;
    send_byte(8'h3C, 1'b1);
    checks++;
    if (pif.portInputWord !== 32'h0) begin failures++; $display("FAIL rx_early: got %h want 0", pif.portInputWord); end
    cyc(2);
    checks++;
    if (pif.portInputWord !== 32'h0000_023C) begin failures++; $display("FAIL rx_3c: got %h want 0000023c", pif.portInputWord); end
    pif.portOutputWord = 32'h0000_0200;
    cyc(2);
    checks++;
    if (pif.portInputWord !== 32'h0000_023C) begin failures++; $display("FAIL rx_ack_no_ovr: got %h want 0000023c", pif.portInputWord); end
  endtask

  task automatic test_overrun;
    send_byte(8'h11, 1'b1);
    cyc(2);
    checks++;
    if (pif.portInputWord !== 32'h0000_0011) begin failures++; $display("FAIL rx_11: got %h want 00000011", pif.portInputWord); end
    send_byte(8'h22, 1'b1);
    cyc(2);
    checks++;
    if (pif.portInputWord !== 32'h0000_0811) begin failures++; $display("FAIL overrun_set: got %h want 00000811", pif.portInputWord); end
    pif.portOutputWord = 32'h0000_0000;
    cyc(1);
    checks++;
    if (pif.portInputWord !== 32'h0000_0011) begin failures++; $display("FAIL overrun_clear: got %h want 00000011", pif.portInputWord); end
    send_byte(8'h44, 1'b1);
    cyc(2);
    checks++;
    if (pif.portInputWord !== 32'h0000_0244) begin failures++; $display("FAIL rx_44: got %h want 00000244", pif.portInputWord); end
    send_byte(8'h33, 1'b1);
    cyc(1);
    pif.portOutputWord = 32'h0000_0200;  // ack lands on the completion edge
    cyc(1);
    checks++;
    if (pif.portInputWord !== 32'h0000_0033) begin failures++; $display("FAIL ack_with_completion: got %h want 00000033", pif.portInputWord); end
    pif.portOutputWord = 32'h0000_0000;
    cyc(2);
  endtask

  task automatic test_errors;
    rxd = 1'b0;
    cyc(1);
    rxd = 1'b1;
    cyc(20);
    checks++;
    if (pif.portInputWord !== 32'h0000_0033) begin failures++; $display("FAIL glitch_ignored: got %h want 00000033", pif.portInputWord); end
    send_byte(8'h55, 1'b0);
    cyc(2);
    checks++;
    if (pif.portInputWord !== 32'h0000_1255) begin failures++; $display("FAIL framing_error: got %h want 00001255", pif.portInputWord); end
    pif.portOutputWord = 32'h0000_0200;
    send_byte(8'h66, 1'b1);
    cyc(2);
    checks++;
    if (pif.portInputWord !== 32'h0000_0066) begin failures++; $display("FAIL ferr_cleared: got %h want 00000066", pif.portInputWord); end
    pif.portOutputWord = 32'h0000_0000;
    cyc(2);
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL txd_idle_during_rx: got %b want 1", txd); end
  endtask

  task automatic test_back_to_back;
    localparam int NLOG = 2 * FL + 60;
    logic       tl [0:NLOG];
    logic [1:0] sl [0:NLOG];
    logic [10:0] f1, f2;
    logic busy_prev;
    int frames, bad;
    f1 = frame_bits(8'h81, 1'b1);
    f2 = frame_bits(8'h42, 1'b1);
    busy_prev = pif.portInputWord[10];
    frames = 0;
    pif.portOutputWord = 32'h0000_0181;
    for (int n = 0; n <= NLOG; n++) begin
      cyc(1);
      tl[n] = txd;
      sl[n] = {pif.portInputWord[10], pif.portInputWord[8]};
      if (sl[n][1] && !busy_prev) frames++;
      busy_prev = sl[n][1];
      if (n == 10) pif.portOutputWord = 32'h0000_0042;
    end
    for (int k = 0; k < FB; k++) begin
      checks++;
      if (tl[k*CPB + 2] !== f1[k]) begin failures++; $display("FAIL b2b_f1_bit%0d: got %b want %b", k, tl[k*CPB + 2], f1[k]); end
    end
    checks++;
    if (tl[FL] !== 1'b1 || sl[FL] !== 2'b01) begin failures++; $display("FAIL b2b_gap: txd %b st %b want 1 01", tl[FL], sl[FL]); end
    checks++;
    if (tl[FL+1] !== 1'b0 || sl[FL+1] !== 2'b11) begin failures++; $display("FAIL b2b_restart: txd %b st %b want 0 11", tl[FL+1], sl[FL+1]); end
    for (int k = 0; k < FB; k++) begin
      checks++;
      if (tl[FL + 1 + k*CPB + 2] !== f2[k]) begin failures++; $display("FAIL b2b_f2_bit%0d: got %b want %b", k, tl[FL + 1 + k*CPB + 2], f2[k]); end
    end
    checks++;
    if (sl[2*FL+1] !== 2'b00) begin failures++; $display("FAIL b2b_second_done: got %b want 00", sl[2*FL+1]); end
    bad = 0;
    for (int n = 2*FL + 1; n <= NLOG; n++) if (tl[n] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_idle_after: %0d low cycles want 0", bad); end
    checks++;
    if (frames != 2) begin failures++; $display("FAIL b2b_frame_count: got %0d want 2", frames); end
    checks++;
    if (pif.portInputWord !== 32'h0000_0066) begin failures++; $display("FAIL b2b_final_status: got %h want 00000066", pif.portInputWord); end
  endtask

  initial begin
    pif.portOutputWord = 32'h0;
    test_reset();
    test_tx();
    test_reset_midframe();
    test_rx();
    test_overrun();
    test_errors();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
